// File: rtl/speed_step_scheduler_pkg.sv
// Shared encodings for the speed status machine and the step scheduler.
package speed_step_scheduler_pkg;

    localparam logic [1:0] ST_LOW   = 2'd0;
    localparam logic [1:0] ST_MID   = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

endpackage

// File: rtl/speed_step_scheduler_prescaler.sv
// Step prescaler: counts 0..div-1 while enabled and flags the terminal count.
module step_prescaler #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             enable,
    input  logic [CNT_W-1:0] div,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Terminal flag ignores restart; the owner decides whether it wins.
    assign tc = enable && (cnt == div - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (enable) begin
            if (tc) cnt <= '0;
            else    cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/speed_step_scheduler.sv
// Turns speed/pause status into timed step pulses and a wrapping read address.
module speed_step_scheduler
    import speed_step_scheduler_pkg::*;
#(
    parameter int DIV_LOW  = 100_000_000,
    parameter int DIV_MID  = 25_000_000,
    parameter int DIV_HIGH = 6_250_000,
    parameter int CNT_W    = 27,
    parameter int ADDR_W   = 7,
    parameter int ADDR_MAX = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        status,
    input  logic              clr,
    input  logic              step_req,
    output logic [ADDR_W-1:0] addr_out,
    output logic              step_pulse,
    output logic              paused,
    output logic              wrap
);

    sched_state_t      state, state_nxt;
    logic [1:0]        status_q, status_q_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              pulse_nxt, wrap_nxt, advance;
    logic              changed, restart, enable, tc;
    logic [CNT_W-1:0]  div;

    assign changed = (status != status_q);
    assign restart = clr || changed || (state == HOLD);
    assign enable  = (state == RUN);

    always_comb begin
        case (status_q)
            ST_LOW:  div = CNT_W'(DIV_LOW);
            ST_HIGH: div = CNT_W'(DIV_HIGH);
            default: div = CNT_W'(DIV_MID);
        endcase
    end

    step_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .enable  (enable),
        .div     (div),
        .tc      (tc)
    );

    always_comb begin
        state_nxt    = state;
        status_q_nxt = status_q;
        addr_nxt     = addr_out;
        pulse_nxt    = 1'b0;
        wrap_nxt     = 1'b0;
        advance      = 1'b0;
        // clr and a status change both swallow a coincident terminal count or step_req
        if (clr || changed) begin
            status_q_nxt = status;
            state_nxt    = (status == ST_PAUSE) ? HOLD : RUN;
            if (clr) addr_nxt = '0;
        end else begin
            case (state)
                RUN:  advance = tc;
                HOLD: advance = step_req;
                default: advance = 1'b0;
            endcase
        end
        if (advance) begin
            pulse_nxt = 1'b1;
            if (addr_out == ADDR_W'(ADDR_MAX)) begin
                addr_nxt = '0;
                wrap_nxt = 1'b1;
            end else begin
                addr_nxt = addr_out + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            status_q   <= ST_MID;
            addr_out   <= '0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
            paused     <= 1'b0;
        end else begin
            state      <= state_nxt;
            status_q   <= status_q_nxt;
            addr_out   <= addr_nxt;
            step_pulse <= pulse_nxt;
            wrap       <= wrap_nxt;
            paused     <= (state_nxt == HOLD);
        end
    end

endmodule

// File: tb/tb_speed_step_scheduler.sv
// Scoreboard bench for speed_step_scheduler with small dividers.
module tb_speed_step_scheduler;

    localparam int DIV_LOW  = 8;
    localparam int DIV_MID  = 4;
    localparam int DIV_HIGH = 2;
    localparam int CNT_W    = 4;
    localparam int ADDR_W   = 3;
    localparam int ADDR_MAX = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        status = 2'd1;
    logic              clr = 1'b0;
    logic              step_req = 1'b0;
    logic [ADDR_W-1:0] addr_out;
    logic              step_pulse, paused, wrap;

    speed_step_scheduler #(
        .DIV_LOW (DIV_LOW),
        .DIV_MID (DIV_MID),
        .DIV_HIGH(DIV_HIGH),
        .CNT_W   (CNT_W),
        .ADDR_W  (ADDR_W),
        .ADDR_MAX(ADDR_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .status    (status),
        .clr       (clr),
        .step_req  (step_req),
        .addr_out  (addr_out),
        .step_pulse(step_pulse),
        .paused    (paused),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int pulse;
        int wrp;
        int pause;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;

    // reference model state
    int m_hold = 0;
    int m_sq   = 1;
    int m_cnt  = 0;
    int m_addr = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int div_of(input int sq);
        case (sq)
            0:       return DIV_LOW;
            2:       return DIV_HIGH;
            default: return DIV_MID;
        endcase
    endfunction

    task automatic model_reset();
        m_hold = 0; m_sq = 1; m_cnt = 0; m_addr = 0;
    endtask

    task automatic tick();
        exp_t e;
        e.pulse = 0;
        e.wrp   = 0;
        if (rst) begin
            model_reset();
        end else if (clr) begin
            m_addr = 0; m_cnt = 0; m_sq = int'(status); m_hold = (status == 2'd3);
        end else if (int'(status) != m_sq) begin
            m_sq = int'(status); m_cnt = 0; m_hold = (status == 2'd3);
        end else if (m_hold != 0) begin
            if (step_req) e.pulse = 1;
        end else if (m_cnt == div_of(m_sq) - 1) begin
            m_cnt = 0; e.pulse = 1;
        end else begin
            m_cnt++;
        end
        if (e.pulse != 0) begin
            if (m_addr == ADDR_MAX) begin m_addr = 0; e.wrp = 1; end
            else m_addr++;
        end
        e.addr  = m_addr;
        e.pause = m_hold;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("addr_out",   int'(addr_out),   e.addr);
        check("step_pulse", int'(step_pulse), e.pulse);
        check("wrap",       int'(wrap),       e.wrp);
        check("paused",     int'(paused),     e.pause);
        if (step_pulse) n_pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: reset then mid-speed stepping
        ticks(3);
        check("reset_addr",   int'(addr_out), 0);
        check("reset_paused", int'(paused),   0);
        rst = 1'b0;
        ticks(12);
        check("mid_addr_after_3", int'(addr_out), 3);

        // 2: rate change mid-count; also step_req ignored in RUN
        step_req = 1'b1;
        ticks(2);
        step_req = 1'b0;
        status = 2'd2;
        ticks(3);

        // 3: high speed through the wrap
        ticks(14);

        // 4: pause, manual steps, resume at low speed
        status = 2'd3;
        n_pulses = 0;
        ticks(20);
        check("pause_no_pulses", n_pulses, 0);
        step_req = 1'b1;
        ticks(2);
        check("pause_two_steps", n_pulses, 2);
        step_req = 1'b0;
        ticks(3);
        status = 2'd0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("resume_paused", int'(paused), 0);
        ticks(10);

        // 5: clr at terminal count with a status change pending
        for (int i = 0; i < 20 && m_cnt != DIV_LOW - 1; i++) tick();
        check("reach_terminal", m_cnt, DIV_LOW - 1);
        status = 2'd1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_addr", int'(addr_out), 0);
        ticks(9);

        // 6: async reset mid-count at addr 3
        for (int i = 0; i < 40 && m_addr != 3; i++) tick();
        check("reach_addr3", m_addr, 3);
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_addr",   int'(addr_out),   0);
        check("async_pulse",  int'(step_pulse), 0);
        check("async_wrap",   int'(wrap),       0);
        check("async_paused", int'(paused),     0);
        ticks(2);
        rst = 1'b0;
        ticks(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/speed_step_scheduler.md
Name: speed_step_scheduler

Overview:
- Turns the 2-bit speed/pause status from the speed status machine into timed step pulses and a wrapping address.
- Sits between the status machine and the display/memory readout datapath.
- Each step advances the read address once. The rate is chosen by status; in pause the address is held and single steps are allowed.

Parameters:
DIV_LOW, 100_000_000, clock cycles per step at status 0 (low speed)
DIV_MID, 25_000_000, clock cycles per step at status 1 (mid speed)
DIV_HIGH, 6_250_000, clock cycles per step at status 2 (high speed)
CNT_W, 27, prescaler width; must hold DIV_LOW-1
ADDR_W, 7, address width
ADDR_MAX, 127, last address before wrap; must be <= 2^ADDR_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
status  in  2  0 low, 1 mid, 2 high, 3 pause; synchronous to clk
clr  in  1  synchronous clear of address and prescaler
step_req  in  1  single-cycle manual step request; honoured only in HOLD
addr_out  out  ADDR_W  current step address
step_pulse  out  1  one-cycle pulse on every address advance
paused  out  1  high while in HOLD
wrap  out  1  one-cycle pulse, coincident with step_pulse, when the address wraps ADDR_MAX->0

Behaviour:
- Reset (rst=1, async): state=RUN, cnt=0, status_q=1, addr_out=0, step_pulse=0, wrap=0, paused=0. Reset mid-count discards all progress.
- All outputs are registered. step_pulse, wrap and the new addr_out become visible together, one edge after the triggering condition.
- status_q holds the registered previous status. Changed = (status != status_q).
- Priority, evaluated per edge:
  1. clr: addr<=0, cnt<=0, no pulse, status_q<=status, state set from status.
  2. Changed: status_q<=status, cnt<=0, no pulse. State becomes HOLD if status==3, else RUN.
  3. State action, as below.
- FSM:
  - RUN: div = DIV_LOW, DIV_MID or DIV_HIGH per status_q.
  - RUN, cnt==div-1: cnt<=0, step_pulse<=1, addr advances.
  - RUN, otherwise: cnt<=cnt+1, step_pulse<=0. step_req is ignored.
  - HOLD: cnt frozen at 0. step_req=1 gives step_pulse<=1 and addr advances. Back-to-back step_req gives back-to-back steps.
  - paused = (state==HOLD), registered.
- Advance: if addr==ADDR_MAX then addr<=0 and wrap<=1, else addr<=addr+1 and wrap<=0.
- Pulse spacing in RUN with stable status is exactly div cycles.
- First pulse after a rate change comes exactly div cycles after the edge that sampled the new status.
- A terminal count coinciding with a status change yields no pulse; the change wins.
- step_req coinciding with clr or a status change is dropped.

Decomposition:
- Shared package: status encodings ST_LOW=0, ST_MID=1, ST_HIGH=2, ST_PAUSE=3, also used by the status machine; FSM state encoding RUN/HOLD.
- One natural sub-module: step_prescaler. It holds the cnt register, takes div and an enable/restart input, and emits the terminal pulse. The address/FSM logic stays in the top.

Test Plan (DIV_LOW=8, DIV_MID=4, DIV_HIGH=2, ADDR_MAX=5):
1. Hold rst 3 cycles, release with status=1 -> addr_out=0, paused=0; step_pulse every 4 cycles; addr_out 1,2,3 after the 1st, 2nd and 3rd pulses.
2. status=1, then status=2 when cnt=2 -> no pulse from the old count; next pulse exactly 2 cycles after the sampling edge, then every 2 cycles.
3. Run at status=2 through addr 5 -> next step gives addr_out=0 with wrap=1 and step_pulse=1 in the same cycle; wrap=0 on every other step.
4. status=3 for 20 cycles -> paused=1 one edge after the change; no step_pulse, addr frozen. Two consecutive step_req cycles -> addr +2, two step_pulses. Return to status=0 -> paused=0, first pulse 8 cycles later.
5. clr asserted with cnt at terminal count and a status change pending -> addr_out=0, no step_pulse, and counting restarts from 0 at the new rate.
6. Assert rst asynchronously mid-count at addr=3 -> outputs return to reset values immediately, without waiting for a clock edge; normal mid-speed stepping resumes after release.
